// File: rtl/reg_native_pkg.sv
// Shared types for the native register forwarder: FSM states, the captured
// request record and the default read data returned on a downstream timeout.
package reg_native_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // The request record is sized for the widest supported port; narrower
  // instances zero-extend on capture and truncate on drive.
  localparam int REQ_ADDR_MAX = 64;
  localparam int REQ_DATA_MAX = 64;

  typedef struct packed {
    logic                    wr_en;
    logic                    rd_en;
    logic [REQ_ADDR_MAX-1:0] addr;
    logic [REQ_DATA_MAX-1:0] wr_data;
  } req_t;

endpackage

// File: rtl/reg_native_fwd_tmr.sv
// Downstream-ack wait counter; only built with REG_NATIVE_FWD_TIMEOUT_EN.
// expired is high during the TIMEOUT_CYCLES-th consecutive cycle of en.
module reg_native_fwd_tmr #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic srst,
  input  logic en,
  output logic expired
);

  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_r;

  assign expired = en && (cnt_r == LAST_CNT);

  // Count consecutive enabled cycles; cleared whenever the wait ends
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= 16'd0;
    end else if (srst || !en) begin
      cnt_r <= 16'd0;
    end else if (cnt_r != LAST_CNT) begin
      cnt_r <= cnt_r + 16'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/reg_native_fwd.sv
// Single-outstanding native register forwarder (IDLE/FWD/WAIT/RESP).
// Optional downstream-ack timeout enabled by macro REG_NATIVE_FWD_TIMEOUT_EN.
module reg_native_fwd
  import reg_native_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = 64,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA       = DATA_WIDTH'(ERR_DATA_DEFAULT)
) (
  input  logic                  fsm_clk,
  input  logic                  fsm_rst,
  input  logic                  soft_rst,
  input  logic                  req_vld,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  ack_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  ds_req_vld,
  output logic                  ds_wr_en,
  output logic                  ds_rd_en,
  output logic [ADDR_WIDTH-1:0] ds_addr,
  output logic [DATA_WIDTH-1:0] ds_wr_data,
  input  logic                  ds_ack_vld,
  input  logic [DATA_WIDTH-1:0] ds_rd_data,
  output logic                  timeout,
  output logic                  req_overrun
);

  state_e                state_r, state_nxt_s;
  req_t                  req_r, req_nxt_s;
  logic [DATA_WIDTH-1:0] resp_data_s;
  logic                  wait_s;
  logic                  tmo_s;

  assign wait_s = (state_r == WAIT);

`ifdef REG_NATIVE_FWD_TIMEOUT_EN
  reg_native_fwd_tmr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_tmr (
    .clk     (fsm_clk),
    .rst     (fsm_rst),
    .srst    (soft_rst),
    .en      (wait_s),
    .expired (tmo_s)
  );
`else
  assign tmo_s = 1'b0;
`endif

  // Next state, next capture contents and response data
  always_comb begin
    state_nxt_s = state_r;
    req_nxt_s   = req_r;
    resp_data_s = '0;
    if (soft_rst) begin
      state_nxt_s = IDLE;
      req_nxt_s   = '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_vld) begin
            state_nxt_s       = FWD;
            req_nxt_s.wr_en   = wr_en;
            req_nxt_s.rd_en   = rd_en;
            req_nxt_s.addr    = REQ_ADDR_MAX'(addr);
            req_nxt_s.wr_data = REQ_DATA_MAX'(wr_data);
          end else begin
            state_nxt_s = IDLE;
          end
        end
        FWD: state_nxt_s = WAIT;
        WAIT: begin
          // A real ack wins over a timeout landing in the same cycle
          if (ds_ack_vld) begin
            state_nxt_s = RESP;
            resp_data_s = req_r.rd_en ? ds_rd_data : '0;
          end else if (tmo_s) begin
            state_nxt_s = RESP;
            resp_data_s = req_r.rd_en ? ERR_DATA : '0;
          end else begin
            state_nxt_s = WAIT;
          end
        end
        RESP:    state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State, capture and registered outputs, all decoded from the next state
  always_ff @(posedge fsm_clk or posedge fsm_rst) begin
    if (fsm_rst) begin
      state_r     <= IDLE;
      req_r       <= '0;
      ack_vld     <= 1'b0;
      rd_data     <= '0;
      ds_req_vld  <= 1'b0;
      ds_wr_en    <= 1'b0;
      ds_rd_en    <= 1'b0;
      ds_addr     <= '0;
      ds_wr_data  <= '0;
      timeout     <= 1'b0;
      req_overrun <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      req_r       <= req_nxt_s;
      ack_vld     <= (state_nxt_s == RESP);
      rd_data     <= (state_nxt_s == RESP) ? resp_data_s : '0;
      ds_req_vld  <= (state_nxt_s == FWD);
      ds_wr_en    <= (state_nxt_s != IDLE) ? req_nxt_s.wr_en : 1'b0;
      ds_rd_en    <= (state_nxt_s != IDLE) ? req_nxt_s.rd_en : 1'b0;
      ds_addr     <= (state_nxt_s != IDLE) ? ADDR_WIDTH'(req_nxt_s.addr) : '0;
      ds_wr_data  <= (state_nxt_s != IDLE) ? DATA_WIDTH'(req_nxt_s.wr_data) : '0;
      timeout     <= !soft_rst && wait_s && !ds_ack_vld && tmo_s;
      req_overrun <= soft_rst ? 1'b0 : (req_overrun || (req_vld && (state_r != IDLE)));
    end
  end

endmodule

// File: tb/tb_reg_native_fwd.sv
// Directed self-checking bench for reg_native_fwd (TIMEOUT_CYCLES=8).
// Timeout scenarios run when REG_NATIVE_FWD_TIMEOUT_EN is defined.
module tb_reg_native_fwd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        soft_rst = 1'b0;
  logic        req_vld = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [63:0] addr = 64'd0;
  logic [31:0] wr_data = 32'd0;
  logic        ack_vld;
  logic [31:0] rd_data;
  logic        ds_req_vld;
  logic        ds_wr_en;
  logic        ds_rd_en;
  logic [63:0] ds_addr;
  logic [31:0] ds_wr_data;
  logic        ds_ack_vld = 1'b0;
  logic [31:0] ds_rd_data = 32'd0;
  logic        timeout;
  logic        req_overrun;

  int checks = 0;
  int failures = 0;

  reg_native_fwd #(
    .ADDR_WIDTH     (64),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .fsm_clk     (clk),
    .fsm_rst     (rst),
    .soft_rst    (soft_rst),
    .req_vld     (req_vld),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .addr        (addr),
    .wr_data     (wr_data),
    .ack_vld     (ack_vld),
    .rd_data     (rd_data),
    .ds_req_vld  (ds_req_vld),
    .ds_wr_en    (ds_wr_en),
    .ds_rd_en    (ds_rd_en),
    .ds_addr     (ds_addr),
    .ds_wr_data  (ds_wr_data),
    .ds_ack_vld  (ds_ack_vld),
    .ds_rd_data  (ds_rd_data),
    .timeout     (timeout),
    .req_overrun (req_overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic r, input logic [63:0] a, input logic [31:0] d);
    req_vld = 1'b1;
    wr_en   = w;
    rd_en   = r;
    addr    = a;
    wr_data = d;
  endtask

  initial begin
    int bad;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack_vld", 64'(ack_vld), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_ds_req_vld", 64'(ds_req_vld), 64'd0);
    chk("rst_ds_addr", ds_addr, 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_overrun", 64'(req_overrun), 64'd0);
    rst = 1'b0;
    step();

    // Write, ack in the third WAIT cycle (cycle 4) -> ack_vld at cycle 5
    issue(1'b1, 1'b0, 64'h10, 32'h1234_5678);
    step();
    req_vld = 1'b0;
    chk("wr_ds_req_vld_c1", 64'(ds_req_vld), 64'd1);
    chk("wr_ds_wr_en", 64'(ds_wr_en), 64'd1);
    chk("wr_ds_rd_en", 64'(ds_rd_en), 64'd0);
    chk("wr_ds_addr", ds_addr, 64'h10);
    chk("wr_ds_wr_data", 64'(ds_wr_data), 64'h1234_5678);
    step();
    chk("wr_ds_req_vld_c2", 64'(ds_req_vld), 64'd0);
    chk("wr_ds_addr_hold", ds_addr, 64'h10);
    step();
    step();
    ds_ack_vld = 1'b1;
    ds_rd_data = 32'hFFFF_FFFF;
    chk("wr_ack_vld_c4", 64'(ack_vld), 64'd0);
    step();
    ds_ack_vld = 1'b0;
    chk("wr_ack_vld_c5", 64'(ack_vld), 64'd1);
    chk("wr_rd_data_c5", 64'(rd_data), 64'd0);
    step();
    chk("wr_ack_vld_c6", 64'(ack_vld), 64'd0);
    chk("wr_ds_addr_idle", ds_addr, 64'd0);

    // Read returning downstream data
    issue(1'b0, 1'b1, 64'h14, 32'd0);
    step();
    req_vld = 1'b0;
    chk("rd_ds_req_vld", 64'(ds_req_vld), 64'd1);
    chk("rd_ds_rd_en", 64'(ds_rd_en), 64'd1);
    chk("rd_ds_addr", ds_addr, 64'h14);
    step();
    ds_ack_vld = 1'b1;
    ds_rd_data = 32'h8765_4321;
    chk("rd_rd_data_wait", 64'(rd_data), 64'd0);
    step();
    ds_ack_vld = 1'b0;
    chk("rd_ack_vld", 64'(ack_vld), 64'd1);
    chk("rd_rd_data", 64'(rd_data), 64'h8765_4321);
    step();
    chk("rd_ack_vld_after", 64'(ack_vld), 64'd0);
    chk("rd_rd_data_after", 64'(rd_data), 64'd0);

    // Neither wr_en nor rd_en: forwarded unchanged, response data zero
    issue(1'b0, 1'b0, 64'h50, 32'h0000_0001);
    step();
    req_vld = 1'b0;
    chk("nop_ds_req_vld", 64'(ds_req_vld), 64'd1);
    chk("nop_ds_en", {62'd0, ds_wr_en, ds_rd_en}, 64'd0);
    chk("nop_ds_addr", ds_addr, 64'h50);
    step();
    ds_ack_vld = 1'b1;
    ds_rd_data = 32'hCAFE_F00D;
    step();
    ds_ack_vld = 1'b0;
    chk("nop_ack_vld", 64'(ack_vld), 64'd1);
    chk("nop_rd_data", 64'(rd_data), 64'd0);
    step();

    // Second request during WAIT is dropped and flags overrun
    issue(1'b1, 1'b0, 64'h20, 32'h0000_00AA);
    step();
    req_vld = 1'b0;
    step();
    issue(1'b1, 1'b0, 64'h99, 32'h0000_00BB);
    step();
    req_vld = 1'b0;
    chk("ovr_flag", 64'(req_overrun), 64'd1);
    chk("ovr_no_second_fwd", 64'(ds_req_vld), 64'd0);
    chk("ovr_ds_addr_kept", ds_addr, 64'h20);
    ds_ack_vld = 1'b1;
    step();
    ds_ack_vld = 1'b0;
    chk("ovr_ack_vld", 64'(ack_vld), 64'd1);
    chk("ovr_ds_req_vld_resp", 64'(ds_req_vld), 64'd0);
    step();
    chk("ovr_sticky", 64'(req_overrun), 64'd1);
    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
    chk("ovr_cleared", 64'(req_overrun), 64'd0);

    // soft_rst during WAIT suppresses the pending ack
    issue(1'b0, 1'b1, 64'h24, 32'd0);
    step();
    req_vld = 1'b0;
    step();
    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
    chk("srst_ds_addr", ds_addr, 64'd0);
    ds_ack_vld = 1'b1;
    ds_rd_data = 32'h1111_2222;
    step();
    ds_ack_vld = 1'b0;
    chk("srst_no_ack", 64'(ack_vld), 64'd0);
    step();
    chk("srst_no_ack_late", 64'(ack_vld), 64'd0);

    // fsm_rst pulse during WAIT abandons the transaction
    issue(1'b0, 1'b1, 64'h30, 32'd0);
    step();
    req_vld = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("arst_outputs", {ds_addr[31:0], 27'd0, ds_req_vld, ds_rd_en, ds_wr_en, ack_vld, timeout}, 64'd0);
    rst = 1'b0;
    step();
    ds_ack_vld = 1'b1;
    ds_rd_data = 32'hAAAA_5555;
    step();
    ds_ack_vld = 1'b0;
    chk("arst_no_ack", 64'(ack_vld), 64'd0);
    chk("arst_rd_data", 64'(rd_data), 64'd0);
    step();
    chk("arst_no_ack_late", 64'(ack_vld), 64'd0);

`ifdef REG_NATIVE_FWD_TIMEOUT_EN
    // Read with no ack: 8 WAIT cycles (2..9), timeout response at cycle 10
    issue(1'b0, 1'b1, 64'h40, 32'd0);
    step();
    req_vld = 1'b0;
    repeat (8) step();
    chk("tmo_ack_vld_c9", 64'(ack_vld), 64'd0);
    step();
    chk("tmo_ack_vld", 64'(ack_vld), 64'd1);
    chk("tmo_pulse", 64'(timeout), 64'd1);
    chk("tmo_rd_data", 64'(rd_data), 64'hDEAD_BEEF);
    ds_ack_vld = 1'b1;
    ds_rd_data = 32'h7777_7777;
    step();
    ds_ack_vld = 1'b0;
    chk("tmo_pulse_end", 64'(timeout), 64'd0);
    step();
    chk("tmo_late_ack_ignored", 64'(ack_vld), 64'd0);

    // Ack in the cycle the counter expires wins over the timeout
    issue(1'b0, 1'b1, 64'h44, 32'd0);
    step();
    req_vld = 1'b0;
    repeat (8) step();
    ds_ack_vld = 1'b1;
    ds_rd_data = 32'h5555_AAAA;
    step();
    ds_ack_vld = 1'b0;
    chk("race_ack_vld", 64'(ack_vld), 64'd1);
    chk("race_rd_data", 64'(rd_data), 64'h5555_AAAA);
    chk("race_no_timeout", 64'(timeout), 64'd0);
    step();
`else
    // Without the timeout feature WAIT lasts until the ack arrives
    issue(1'b0, 1'b1, 64'h40, 32'd0);
    step();
    req_vld = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ack_vld !== 1'b0 || timeout !== 1'b0) bad++;
    end
    chk("notmo_long_wait", 64'(bad), 64'd0);
    ds_ack_vld = 1'b1;
    ds_rd_data = 32'h0BAD_F00D;
    step();
    ds_ack_vld = 1'b0;
    chk("notmo_ack_vld", 64'(ack_vld), 64'd1);
    chk("notmo_rd_data", 64'(rd_data), 64'h0BAD_F00D);
    chk("notmo_timeout", 64'(timeout), 64'd0);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
